// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM signal and reports its period, its high
// time and its duty cycle on a 0..PWM_S_CNT scale. This is the same scale as the
// LED PWM on_time values, so a measured duty can drive an LED PWM directly. A dead
// input, stuck high or stuck low, is reported through timeout.
//
// Ports
//   CLOCK_50   in   1       system clock
//   RESET      in   1       synchronous, active-high reset
//   pwm_in     in   1       asynchronous PWM input
//   duty       out  DUTY_W  last measured duty, 0..PWM_S_CNT
//   period     out  CNT_W   last measured period, in clock cycles
//   high_time  out  CNT_W   last measured high time, in clock cycles
//   valid      out  1       one-cycle pulse when duty/period/high_time update
//   timeout    out  1       level: no rising edge for TIMEOUT_CYC cycles
//   overrun    out  1       one-cycle pulse: a period was dropped during a divide
//
// Build option
//   GLITCH_FILTER_EN  when defined, the synchronized input must hold a new level
//                     for FILTER_LEN consecutive samples before it is accepted.
//                     This adds FILTER_LEN cycles of edge latency. When undefined,
//                     every one-cycle pulse counts as an edge.
//
// Timing: valid rises DUTY_W+1 clocks after the clock edge that samples a rise.
// Rising edges closer together than DUTY_W+2 cycles overlap a divide and are
// dropped, and overrun flags each dropped edge.

module pwm_capture #(
  parameter int unsigned PWM_S_CNT   = 200,
  parameter int unsigned DUTY_W      = 8,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              timeout,
  output logic              overrun
);

  localparam int unsigned NUM_W     = CNT_W + DUTY_W;
  localparam int unsigned DIV_CNT_W = $clog2(DUTY_W + 1);

  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]     TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DUTY_W-1:0]    DUTY_FULL = DUTY_W'(PWM_S_CNT);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST  = DIV_CNT_W'(DUTY_W);

  // Elaboration-time guard on the parameter set.
  if (FILTER_LEN == 0 || PWM_S_CNT >= (2 ** DUTY_W)) begin : g_bad_params
    $error("pwm_capture: FILTER_LEN must be >0 and PWM_S_CNT < 2**DUTY_W");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted input level s
  // ---------------------------------------------------------------------------
  logic s;

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

  logic [FLT_W-1:0] flt_cnt;

  // flt_cnt counts consecutive samples that differ from s. Any sample that
  // agrees with s sets the count back to 0, so a short glitch is dropped.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s       <= 1'b0;
      flt_cnt <= '0;
    end else if (sync2 == s) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      s       <= sync2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end
`else
  assign s = sync2;
`endif

  // ---------------------------------------------------------------------------
  // Rising-edge detector
  // ---------------------------------------------------------------------------
  logic s_prev;
  logic rise_c;

  assign rise_c = s & ~s_prev;

  // ---------------------------------------------------------------------------
  // Measurement datapath helpers
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      per_cnt;
  logic [CNT_W-1:0]      hi_cnt;
  logic [CNT_W-1:0]      idle_cnt;
  logic [CNT_W-1:0]      per_l;
  logic [CNT_W-1:0]      hi_l;
  logic [CNT_W-1:0]      rem;
  logic [DUTY_W-1:0]     sh;
  logic [DUTY_W-1:0]     quo;
  logic [DIV_CNT_W-1:0]  div_cnt;

  logic [CNT_W-1:0]      per_inc_c;
  logic [CNT_W-1:0]      hi_inc_c;
  logic [CNT_W-1:0]      idle_inc_c;
  logic [NUM_W-1:0]      num_c;
  logic [CNT_W:0]        trial_c;
  logic [CNT_W:0]        dvs_c;
  logic                  ge_c;
  logic [CNT_W-1:0]      rem_nxt_c;

  // Saturating increments. per_inc_c is also the period latched at a rise,
  // which covers the rise cycle itself.
  assign per_inc_c  = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
  assign hi_inc_c   = (s && (hi_cnt != CNT_MAX)) ? hi_cnt + CNT_ONE : hi_cnt;
  assign idle_inc_c = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + CNT_ONE;

  // Dividend: the high time scaled to the duty full-scale.
  assign num_c = NUM_W'(hi_cnt) * NUM_W'(PWM_S_CNT);

  // One restoring-divide step. rem stays below per_l, so the result of the
  // trial subtraction always fits back in CNT_W bits.
  assign trial_c   = {rem, sh[DUTY_W-1]};
  assign dvs_c     = {1'b0, per_l};
  assign ge_c      = (trial_c >= dvs_c);
  assign rem_nxt_c = ge_c ? CNT_W'(trial_c - dvs_c) : trial_c[CNT_W-1:0];

  // ---------------------------------------------------------------------------
  // Control FSM, counters, divider and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= IDLE;
      s_prev    <= 1'b0;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      idle_cnt  <= '0;
      per_l     <= '0;
      hi_l      <= '0;
      rem       <= '0;
      sh        <= '0;
      quo       <= '0;
      div_cnt   <= '0;
      duty      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      s_prev  <= s;

      case (state)
        // Wait for the first rise; the partial period before it is discarded.
        IDLE: begin
          if (rise_c) begin
            // The rise cycle is the first high cycle of the new period.
            per_cnt  <= '0;
            hi_cnt   <= CNT_ONE;
            idle_cnt <= '0;
            timeout  <= 1'b0;
            state    <= MEASURE;
          end else begin
            idle_cnt <= idle_inc_c;
            // Only the first timeout after reset comes from here. After a
            // timeout from MEASURE, timeout is already set, so it does not fire again.
            if (!timeout && (idle_cnt == TO_LAST)) begin
              timeout   <= 1'b1;
              duty      <= s ? DUTY_FULL : '0;
              period    <= '0;
              high_time <= '0;
              valid     <= 1'b1;
            end
          end
        end

        // Count the period and the high time until the next rise or a timeout.
        MEASURE: begin
          if (rise_c) begin
            per_l   <= per_inc_c;
            hi_l    <= hi_cnt;
            rem     <= num_c[NUM_W-1:DUTY_W];
            sh      <= num_c[DUTY_W-1:0];
            quo     <= '0;
            div_cnt <= '0;
            per_cnt <= '0;
            hi_cnt  <= CNT_ONE;
            timeout <= 1'b0;
            state   <= DIVIDE;
          end else if (per_cnt == TO_LAST) begin
            timeout   <= 1'b1;
            duty      <= s ? DUTY_FULL : '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b1;
            idle_cnt  <= '0;
            state     <= IDLE;
          end else begin
            per_cnt <= per_inc_c;
            hi_cnt  <= hi_inc_c;
          end
        end

        // DUTY_W quotient steps, then one cycle that loads the outputs. The
        // counters keep running, and a rise here drops the period that just ended.
        DIVIDE: begin
          if (rise_c) begin
            per_cnt <= '0;
            hi_cnt  <= CNT_ONE;
            overrun <= 1'b1;
          end else begin
            per_cnt <= per_inc_c;
            hi_cnt  <= hi_inc_c;
          end

          if (div_cnt == DIV_LAST) begin
            duty      <= quo;
            period    <= per_l;
            high_time <= hi_l;
            valid     <= 1'b1;
            state     <= MEASURE;
          end else begin
            rem     <= rem_nxt_c;
            sh      <= {sh[DUTY_W-2:0], 1'b0};
            quo     <= {quo[DUTY_W-2:0], ge_c};
            div_cnt <= div_cnt + DIV_CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
